// File: rtl/rx_descrambler_pkg.sv
// Shared definitions for the rx_descrambler slice: FSM encoding, data width and
// the keystream step used by the prbs generator.
package rx_descrambler_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_RUN      = 2'd2
  } rx_state_e;

  // One keystream word per step: xorshift32 (13, 17, 5). Word K0 is the seed itself.
  function automatic logic [DATA_W-1:0] prbs_next(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/rx_descrambler_prbs.sv
// Keystream generator: reload loads the seed (K0 visible next cycle), run advances
// one word; reload wins over run.
module rx_descrambler_prbs
  import rx_descrambler_pkg::*;
(
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              i_run,
  input  logic              i_reload,
  input  logic [DATA_W-1:0] i_seed,
  output logic [DATA_W-1:0] o_prbs
);

  logic [DATA_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_reload) begin
      lfsr_d = i_seed;
    end else if (i_run) begin
      lfsr_d = prbs_next(lfsr_q);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_prbs = lfsr_q;

endmodule

// File: rtl/rx_descrambler.sv
// Frame-synchronised stream descrambler with a single output register stage.
// Optional frame counter enabled by defining RX_FRAME_CNT_EN.
module rx_descrambler
  import rx_descrambler_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    i_rx_enable,
  input  logic [C_DATA_WIDTH-1:0] i_prbs_seed,
  input  logic                    i_prbs_reload,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_sof,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    o_sync,
  output logic [C_CNT_WIDTH-1:0]  o_drop_cnt,
  output logic [31:0]             o_frame_cnt
);

  rx_state_e               state_q, state_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [C_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [C_CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                    sync_q, sync_d;

  logic                    resync, in_ready, beat_acc, sof_acc, drop_acc, data_acc;
  logic                    prbs_run, prbs_reload;
  logic [DATA_W-1:0]       prbs_word;

  rx_descrambler_prbs u_prbs (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .i_run         (prbs_run),
    .i_reload      (prbs_reload),
    .i_seed        (i_prbs_seed),
    .o_prbs        (prbs_word)
  );

  // A host reload also stalls the input for that cycle so no beat meets a stale keystream.
  always_comb begin
    resync = (state_q == ST_RUN) && s_axis_tvalid && s_axis_sof;
    if (state_q == ST_IDLE) begin
      in_ready = 1'b1;
    end else begin
      in_ready = (!m_tvalid_q || m_axis_tready) && !resync && !i_prbs_reload;
    end
    beat_acc = s_axis_tvalid && in_ready;
    sof_acc  = beat_acc && (state_q == ST_WAIT_SOF) && s_axis_sof;
    drop_acc = beat_acc && (state_q == ST_WAIT_SOF) && !s_axis_sof;
    data_acc = sof_acc || (beat_acc && (state_q == ST_RUN));
    prbs_run = data_acc;

    case (state_q)
      ST_IDLE:     prbs_reload = 1'b1;
      ST_WAIT_SOF: prbs_reload = !sof_acc;
      ST_RUN:      prbs_reload = resync || i_prbs_reload;
      default:     prbs_reload = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!i_rx_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_WAIT_SOF;
        ST_WAIT_SOF: if (!i_prbs_reload && sof_acc) state_d = ST_RUN;
        ST_RUN:      if (i_prbs_reload || resync) state_d = ST_WAIT_SOF;
        default:     state_d = ST_IDLE;
      endcase
    end
    sync_d = (state_d == ST_RUN);
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q && !m_axis_tready;
    m_tdata_d  = m_tdata_q;
    if (data_acc) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_axis_tdata ^ prbs_word;
    end
    drop_cnt_d = drop_cnt_q;
    if (drop_acc && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + C_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= ST_IDLE;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      drop_cnt_q <= '0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      drop_cnt_q <= drop_cnt_d;
      sync_q     <= sync_d;
    end
  end

`ifdef RX_FRAME_CNT_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (sof_acc) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`else
  assign o_frame_cnt = '0;
`endif

  assign s_axis_tready = in_ready;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_sync        = sync_q;

endmodule
